alu_issue_ctrl: RTL

//   Sequencing stage directly upstream of the 32-bit ALU (alu32) in the MIPS calculator datapath.

---
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Operation handshake (in_*) and result handshake (res_*) around alu_issue_ctrl.
// master = producer of operations / consumer of results; slave = the issue stage.
interface alu_issue_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_use_acc;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_overflow;
   logic        res_zero;
   logic        res_negative;

   modport master (
      output in_valid, in_op, in_a, in_b, in_use_acc, res_ready,
      input  in_ready, res_valid, res_data, res_overflow, res_zero, res_negative
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_use_acc, res_ready,
      output in_ready, res_valid, res_data, res_overflow, res_zero, res_negative
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of alu32: registers one operation, lets the ALU settle for a cycle,
// then captures the result into a held buffer along with accumulator, sticky overflow and op counter.
module alu_issue_ctrl #(
   parameter int unsigned CNT_W    = 16,
   parameter logic [31:0] ACC_INIT = 32'd0
) (
   input  logic             clk,
   input  logic             reset,
   alu_issue_ctrl_if.slave  bus,
   output logic [31:0]      alu_A,
   output logic [31:0]      alu_B,
   output logic [2:0]       alu_control,
   input  logic [31:0]      alu_out,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   input  logic             alu_negative,
   input  logic             clr_sticky,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_reg;
   logic [31:0]      alu_a_reg;
   logic [31:0]      alu_b_reg;
   logic [2:0]       alu_ctl_reg;
   logic [31:0]      acc_reg;
   logic             res_valid_reg;
   logic [31:0]      res_data_reg;
   logic             res_ovf_reg;
   logic             res_zero_reg;
   logic             res_neg_reg;
   logic             sticky_reg;
   logic [CNT_W-1:0] op_count_reg;

   logic             in_ready_int;
   logic             accept;
   logic             exec_exit;
   logic [31:0]      operand_a;

   // In HOLD the buffer frees up in the same cycle the consumer takes it, giving back-to-back issue.
   assign in_ready_int = (state_reg == IDLE) || ((state_reg == HOLD) && bus.res_ready);
   assign accept       = bus.in_valid && in_ready_int;
   assign exec_exit    = (state_reg == EXEC);
   assign operand_a    = bus.in_use_acc ? acc_reg : bus.in_a;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         alu_a_reg     <= 32'd0;
         alu_b_reg     <= 32'd0;
         alu_ctl_reg   <= 3'd0;
         acc_reg       <= ACC_INIT;
         res_valid_reg <= 1'b0;
         res_data_reg  <= 32'd0;
         res_ovf_reg   <= 1'b0;
         res_zero_reg  <= 1'b0;
         res_neg_reg   <= 1'b0;
         sticky_reg    <= 1'b0;
         op_count_reg  <= '0;
      end else begin
         // A capture with overflow takes priority over a simultaneous clear.
         sticky_reg <= (clr_sticky ? 1'b0 : sticky_reg) | (exec_exit & alu_overflow);

         if (accept) begin
            alu_a_reg   <= operand_a;
            alu_b_reg   <= bus.in_b;
            alu_ctl_reg <= bus.in_op;
         end

         case (state_reg)
            IDLE: begin
               res_valid_reg <= 1'b0;
               if (accept) begin
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               res_data_reg  <= alu_out;
               res_ovf_reg   <= alu_overflow;
               res_zero_reg  <= alu_zero;
               res_neg_reg   <= alu_negative;
               acc_reg       <= alu_out;
               op_count_reg  <= op_count_reg + CNT_W'(1);
               res_valid_reg <= 1'b1;
               state_reg     <= HOLD;
            end
            HOLD: begin
               if (bus.res_ready) begin
                  res_valid_reg <= 1'b0;
                  state_reg     <= bus.in_valid ? EXEC : IDLE;
               end
            end
            default: begin
               res_valid_reg <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_int;
   assign bus.res_valid    = res_valid_reg;
   assign bus.res_data     = res_data_reg;
   assign bus.res_overflow = res_ovf_reg;
   assign bus.res_zero     = res_zero_reg;
   assign bus.res_negative = res_neg_reg;
   assign alu_A            = alu_a_reg;
   assign alu_B            = alu_b_reg;
   assign alu_control      = alu_ctl_reg;
   assign sticky_ovf       = sticky_reg;
   assign op_count         = op_count_reg;
endmodule
